// File: rtl/ftdi_tx_arbiter_if.sv
// Byte-stream bundle between the on-chip sources, the arbiter and the ft232h write port.
//   s_tdata  : packed source bytes, source i in [8i+7:8i]
//   s_tvalid : per-source valid
//   s_tlast  : per-source end-of-packet
//   s_tready : per-source ready (driven by the arbiter)
//   m_tdata  : merged byte towards ft232h (driven by the arbiter)
//   m_tvalid : merged valid (driven by the arbiter)
//   m_tready : ft232h ready
// The slave modport is the arbiter's view; the master modport is the view of whatever
// drives the sources and sinks the merged stream.
interface ftdi_tx_arbiter_if #(
    parameter int unsigned NUM_SOURCES = 4
);
    logic [8*NUM_SOURCES-1:0] s_tdata;
    logic [NUM_SOURCES-1:0]   s_tvalid;
    logic [NUM_SOURCES-1:0]   s_tlast;
    logic [NUM_SOURCES-1:0]   s_tready;
    logic [7:0]               m_tdata;
    logic                     m_tvalid;
    logic                     m_tready;

    modport slave (
        input  s_tdata, s_tvalid, s_tlast, m_tready,
        output s_tready, m_tdata, m_tvalid
    );

    modport master (
        output s_tdata, s_tvalid, s_tlast, m_tready,
        input  s_tready, m_tdata, m_tvalid
    );
endinterface

// File: rtl/ftdi_tx_arbiter.sv
// Round-robin packet arbiter in front of the ft232h write port. Each grant emits a
// one-byte channel header {2'b10, cont, 1'b0, id[3:0]} followed by at most MAX_BURST
// payload bytes passed straight through from the granted source.
//   sys_clk : clock, rising edge
//   rst_n   : synchronous active-low reset
//   enable  : permits new grants, looked at only while idle
//   bus     : source and ft232h streams (slave modport)
//   grant   : one-hot current owner, zero while idle
//   busy    : high while a header or payload is in flight
module ftdi_tx_arbiter #(
    parameter int unsigned NUM_SOURCES = 4,
    parameter int unsigned MAX_BURST   = 64
) (
    input  logic                   sys_clk,
    input  logic                   rst_n,
    input  logic                   enable,
    ftdi_tx_arbiter_if.slave       bus,
    output logic [NUM_SOURCES-1:0] grant,
    output logic                   busy
);
    localparam int unsigned IdxW = (NUM_SOURCES > 1) ? $clog2(NUM_SOURCES) : 1;

    typedef enum logic [1:0] {StIdle, StHeader, StPayload} state_e;

    state_e                 state_q;
    logic [IdxW-1:0]        last_ptr_q;
    logic [IdxW-1:0]        gidx_q;
    logic [NUM_SOURCES-1:0] grant_q;
    logic [NUM_SOURCES-1:0] midpkt_q;
    logic [7:0]             hdr_q;
    logic [7:0]             cnt_q;
    logic                   busy_q;

    // Round-robin search starting just above the previous owner.
    logic [IdxW:0]          cand;
    logic [IdxW-1:0]        pick_idx;
    logic                   pick_found;
    logic [NUM_SOURCES-1:0] pick_oh;

    always_comb begin
        cand       = '0;
        pick_idx   = '0;
        pick_found = 1'b0;
        pick_oh    = '0;
        for (int k = 1; k <= int'(NUM_SOURCES); k++) begin
            cand = {1'b0, last_ptr_q} + (IdxW+1)'(k);
            if (cand >= (IdxW+1)'(NUM_SOURCES)) begin
                cand = cand - (IdxW+1)'(NUM_SOURCES);
            end
            if (!pick_found && bus.s_tvalid[cand[IdxW-1:0]]) begin
                pick_found = 1'b1;
                pick_idx   = cand[IdxW-1:0];
            end
        end
        pick_oh[pick_idx] = 1'b1;
    end

    // Granted source's stream, selected by the registered owner index.
    logic [7:0] g_tdata;
    logic       g_tvalid;
    logic       g_tlast;

    always_comb begin
        g_tdata  = '0;
        g_tvalid = 1'b0;
        g_tlast  = 1'b0;
        for (int i = 0; i < int'(NUM_SOURCES); i++) begin
            if (gidx_q == IdxW'(i)) begin
                g_tdata  = bus.s_tdata[8*i +: 8];
                g_tvalid = bus.s_tvalid[i];
                g_tlast  = bus.s_tlast[i];
            end
        end
    end

    // Output mux; m_tvalid never looks at m_tready.
    always_comb begin
        bus.m_tdata  = '0;
        bus.m_tvalid = 1'b0;
        bus.s_tready = '0;
        case (state_q)
            StHeader: begin
                bus.m_tdata  = hdr_q;
                bus.m_tvalid = 1'b1;
            end
            StPayload: begin
                bus.m_tdata  = g_tdata;
                bus.m_tvalid = g_tvalid;
                bus.s_tready = grant_q & {NUM_SOURCES{bus.m_tready}};
            end
            default: ;
        endcase
    end

    logic beat;
    assign beat = bus.m_tvalid & bus.m_tready;

    always_ff @(posedge sys_clk) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            last_ptr_q <= IdxW'(NUM_SOURCES - 1);
            gidx_q     <= '0;
            grant_q    <= '0;
            midpkt_q   <= '0;
            hdr_q      <= '0;
            cnt_q      <= '0;
            busy_q     <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (enable && pick_found) begin
                        gidx_q  <= pick_idx;
                        grant_q <= pick_oh;
                        hdr_q   <= {2'b10, midpkt_q[pick_idx], 1'b0, 4'(pick_idx)};
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= StHeader;
                    end
                end
                StHeader: begin
                    if (beat) begin
                        state_q <= StPayload;
                    end
                end
                StPayload: begin
                    if (beat) begin
                        // tlast takes priority over the burst cap, so a packet ending
                        // exactly at MAX_BURST is not flagged as continued.
                        if (g_tlast) begin
                            midpkt_q[gidx_q] <= 1'b0;
                            last_ptr_q       <= gidx_q;
                            grant_q          <= '0;
                            busy_q           <= 1'b0;
                            state_q          <= StIdle;
                        end else if (cnt_q == 8'(MAX_BURST - 1)) begin
                            midpkt_q[gidx_q] <= 1'b1;
                            last_ptr_q       <= gidx_q;
                            grant_q          <= '0;
                            busy_q           <= 1'b0;
                            state_q          <= StIdle;
                        end else begin
                            cnt_q <= cnt_q + 8'd1;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign grant = grant_q;
    assign busy  = busy_q;
endmodule

// File: doc/ftdi_tx_arbiter.md
# ftdi_tx_arbiter

Round-robin packet arbiter that shares the single byte-wide AXI-Stream write port of the `ft232h` controller between up to 16 on-chip byte sources (ADC channels, debug log, status). It runs in the `sys_clk` domain, upstream of the `ft232h` write-side FIFO. It prefixes every burst with a one-byte channel header so the PC can demultiplexe the stream. It caps each grant at `MAX_BURST` payload bytes so that one long packet cannot starve the other sources.

## Interface

Parameters:
- `NUM_SOURCES`, default 4: number of requesters, legal range 1..16.
- `MAX_BURST`, default 64: maximum payload bytes per grant, legal range 1..255.

Ports:
- `sys_clk`  in  1: single clock. All logic runs on its rising edge.
- `rst_n`  in  1: synchronous, active-low reset.
- `enable`  in  1: permits new grants. It is sampled only in IDLE.
- `s_tdata`  in  8*NUM_SOURCES: source bytes. Source i occupies bits [8i+7:8i].
- `s_tvalid`  in  NUM_SOURCES: per-source valid.
- `s_tlast`  in  NUM_SOURCES: per-source end-of-packet.
- `s_tready`  out  NUM_SOURCES: per-source ready.
- `m_tdata`  out  8: byte to `ft232h` `tdata`.
- `m_tvalid`  out  1: to `ft232h` `tvalid`.
- `m_tready`  in  1: from `ft232h` `tready`.
- `grant`  out  NUM_SOURCES: one-hot current owner. All zero in IDLE.
- `busy`  out  1: high in HEADER or PAYLOAD.

## Operation

- The state machine has three states: IDLE, HEADER, PAYLOAD.
- A beat is any cycle in which `m_tvalid` and `m_tready` are both high.
- Registered state:
  - `last_ptr`: index of the last granted source. Reset value is NUM_SOURCES-1.
  - `grant`.
  - `hdr`: 8-bit header register.
  - `cnt`: 8-bit payload beat counter.
  - `midpkt[NUM_SOURCES]`: set when a source's packet was cut at MAX_BURST.
- IDLE, when `enable` is high and any `s_tvalid` is high:
  - Grant the first valid source found searching upward from `last_ptr`+1, wrapping modulo NUM_SOURCES.
  - Load `hdr = {2'b10, midpkt[g], 1'b0, g[3:0]}`.
  - Clear `cnt` and go to HEADER.
  - Otherwise stay in IDLE.
- HEADER:
  - Drive `m_tdata = hdr` and `m_tvalid = 1`. All `s_tready` are 0.
  - On a beat, go to PAYLOAD.
- PAYLOAD is a combinational passthrough of the granted source:
  - `m_tdata = s_tdata[g]`, `m_tvalid = s_tvalid[g]`, `s_tready[g] = m_tready`.
  - All other `s_tready` are 0.
- On each beat in PAYLOAD:
  - If `s_tlast[g]`: clear `midpkt[g]`, set `last_ptr = g`, go to IDLE.
  - Else if `cnt+1 == MAX_BURST`: set `midpkt[g]`, set `last_ptr = g`, go to IDLE.
  - Else increment `cnt`.
- Source stalls: if the granted source drops `s_tvalid` mid-packet, the arbiter waits indefinitely. There is no timeout and `cnt` does not advance.
- `enable` falling during HEADER or PAYLOAD does not abort the burst. The burst completes, then no new grant is issued.
- Ungranted sources wait. The arbiter never drops or duplicates bytes.
- `s_tlast` on the beat that also reaches MAX_BURST: tlast wins. `midpkt` is cleared.
- With NUM_SOURCES=1, the search always returns source 0.
- Width rules:
  - `cnt` is 8 bits and never exceeds MAX_BURST-1.
  - Header id bits above the source index are 0.

## Timing

- Reset: on a `sys_clk` edge with `rst_n` low, the state goes to IDLE, `last_ptr` to NUM_SOURCES-1, `midpkt` to 0, and `cnt` and `hdr` to 0.
- Output values during and immediately after reset:
  - `m_tvalid` = 0
  - `m_tdata` = 0
  - `s_tready` = 0
  - `grant` = 0
  - `busy` = 0
- Reset mid-burst discards the remainder of the grant. The source keeps its data, and its next packet gets a fresh header with cont = 0.
- Arbitration latency: a request seen in IDLE at edge N produces the header on `m_tdata` with `m_tvalid` high from edge N+1.
- Per-burst overhead: 1 IDLE cycle plus 1 header beat. The minimum gap between the last payload byte of one burst and the first payload byte of the next is 2 cycles.
- PAYLOAD has zero latency: the source byte appears on `m_tdata` in the same cycle.
- AXIS rules:
  - While `m_tvalid` is high and `m_tready` is low, `m_tdata` and `m_tvalid` hold stable. In PAYLOAD this relies on the source obeying AXIS.
  - `m_tvalid` never depends combinationally on `m_tready`.
- Throughput: with `m_tready` high continuously, one byte per cycle in PAYLOAD.

## Test plan

- **Single packet.** Source 0 sends 0x11, 0x22, 0x33 (tlast on 0x33), `m_tready`=1 -> `m_tdata` beats are 0x80, 0x11, 0x22, 0x33. `grant` = 0b0001 for 4 cycles, then 0. `busy` falls the cycle after 0x33.
- **Round-robin.** Sources 0 and 2 continuously offer 1-byte tlast packets -> header sequence 0x80, 0x82, 0x80, 0x82. Source 0 is first after reset. Sources 1 and 3 are never granted.
- **Burst split.** MAX_BURST=4, source 1 sends b0..b9 with tlast on b9 -> 0x81, b0-b3, 0xA1, b4-b7, 0xA1, b8, b9. `midpkt[1]` reads 0 after b9.
- **Backpressure.** `m_tready` toggles every cycle and source 3 sends 8 bytes -> the output reads 0x83 followed by the 8 bytes in order, with no loss or duplication. `m_tdata` is stable on every valid-not-ready cycle.
- **Reset mid-payload.** `rst_n` is low for 1 cycle after the 2nd payload byte of source 2 -> `m_tvalid`, `grant` and `busy` are 0 the next cycle. The next grant to source 2 emits header 0x82.
- **Enable.** `enable` drops during a source 0 packet -> the packet completes through tlast. No header follows while `enable`=0 even with requests pending. After `enable` returns to 1, a header appears one cycle later.
